// File: rtl/vote_pkg.sv
// Shared definitions for the vote collector and the downstream majority detector.
package vote_pkg;
  localparam int N_VOTES = 13;
  localparam int VOTE_W  = 4;
  localparam int CNT_W   = $clog2(N_VOTES + 1);

  typedef logic [VOTE_W-1:0] vote_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } vc_state_t;
endpackage

// File: rtl/vote_slot_bank.sv
// Register file of vote slots: one indexed write port, synchronous clear, all slots readable at once.
module vote_slot_bank #(
  parameter int N_VOTES = vote_pkg::N_VOTES,
  parameter int VOTE_W  = vote_pkg::VOTE_W,
  parameter int CNT_W   = vote_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      we,
  input  logic [CNT_W-1:0]          waddr,
  input  logic [VOTE_W-1:0]         wdata,
  output logic [N_VOTES*VOTE_W-1:0] rdata
);
  import vote_pkg::*;

  genvar gi;
  generate
    for (gi = 0; gi < N_VOTES; gi++) begin : g_slot
      logic [VOTE_W-1:0] slot_reg;

      // Clear wins over a write landing in the same cycle.
      always_ff @(posedge clk) begin
        if (clr) begin
          slot_reg <= '0;
        end else if (we && (waddr == CNT_W'(gi))) begin
          slot_reg <= wdata;
        end
      end

      assign rdata[gi*VOTE_W +: VOTE_W] = slot_reg;
    end
  endgenerate
endmodule

// File: rtl/vote_collector.sv
// Serial-to-parallel vote front end: collects N_VOTES handshaked votes, then holds the frame until acknowledged.
module vote_collector #(
  parameter int N_VOTES = vote_pkg::N_VOTES,
  parameter int VOTE_W  = vote_pkg::VOTE_W,
  parameter int CNT_W   = vote_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [VOTE_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [N_VOTES*VOTE_W-1:0] out_data,
  input  logic                      out_ack,
  output logic [CNT_W-1:0]          count
);
  import vote_pkg::*;

  vc_state_t        state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             slot_we;
  logic             slot_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    slot_we    = 1'b0;
    slot_clr   = !rst_n;
    if (flush) begin
      state_next = FILL;
      count_next = '0;
      slot_clr   = 1'b1;
    end else begin
      case (state_reg)
        IDLE: state_next = FILL;
        FILL: begin
          if (in_valid) begin
            slot_we    = 1'b1;
            count_next = CNT_W'(count_reg + 1'b1);
            if (count_reg == CNT_W'(N_VOTES - 1)) begin
              state_next = FULL;
            end
          end
        end
        FULL: begin
          if (out_ack) begin
            state_next = FILL;
            count_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Handshake outputs depend on the state register only.
  assign in_ready  = (state_reg == FILL);
  assign out_valid = (state_reg == FULL);
  assign count     = count_reg;

  vote_slot_bank #(
    .N_VOTES(N_VOTES),
    .VOTE_W (VOTE_W),
    .CNT_W  (CNT_W)
  ) u_bank (
    .clk  (clk),
    .clr  (slot_clr),
    .we   (slot_we),
    .waddr(count_reg),
    .wdata(in_data),
    .rdata(out_data)
  );
endmodule

// File: tb/tb_vote_collector.sv
// Bench for vote_collector: queue-based reference model checked every cycle, plus directed literal checks.
module tb_vote_collector;
  import vote_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      in_valid = 1'b1;
  logic [VOTE_W-1:0]         in_data = 4'h5;
  logic                      in_ready;
  logic                      flush = 1'b0;
  logic                      out_valid;
  logic [N_VOTES*VOTE_W-1:0] out_data;
  logic                      out_ack = 1'b0;
  logic [CNT_W-1:0]          count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  // Reference model: votes of the current frame in a queue, slot contents in an array.
  bit armed_m = 0;
  int held_m[$];
  int slot_m[N_VOTES];

  vote_collector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ack  (out_ack),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    bit rdy;
    int guard;
    in_valid = 1'b1;
    in_data  = VOTE_W'(v);
    guard    = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic ack_frame();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  initial begin
    foreach (slot_m[k]) slot_m[k] = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        armed_m = 0;
        held_m.delete();
        foreach (slot_m[k]) slot_m[k] = 0;
      end else if (flush) begin
        armed_m = 1;
        held_m.delete();
        foreach (slot_m[k]) slot_m[k] = 0;
      end else if (!armed_m) begin
        armed_m = 1;
      end else if (held_m.size() == N_VOTES) begin
        if (out_ack) held_m.delete();
      end else if (in_valid) begin
        slot_m[held_m.size()] = int'(in_data);
        held_m.push_back(int'(in_data));
      end
    end
  end

  initial begin
    logic [63:0] exp_data;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_data = '0;
        for (int k = 0; k < N_VOTES; k++) exp_data |= 64'(slot_m[k]) << (VOTE_W * k);
        check("model_in_ready", 64'(in_ready), 64'(armed_m && held_m.size() < N_VOTES));
        check("model_out_valid", 64'(out_valid), 64'(held_m.size() == N_VOTES));
        check("model_count", 64'(count), 64'(held_m.size()));
        check("model_out_data", 64'(out_data), exp_data);
      end
    end
  end

  initial begin
    logic [63:0] frame_seq;
    int gap;
    frame_seq = '0;
    for (int i = 1; i <= N_VOTES; i++) frame_seq |= 64'(i) << (VOTE_W * (i - 1));

    // Reset held with a vote offered
    tick();
    chk_en = 1;
    tick();
    tick();
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("release_cycle1_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("release_cycle2_ready", 64'(in_ready), 64'd1);
    tick();

    // Back-to-back full frame 1..13
    for (int i = 1; i <= N_VOTES; i++) send(i);
    @(negedge clk);
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_count", 64'(count), 64'(N_VOTES));
    check("full_slot0", 64'(out_data[3:0]), 64'h1);
    check("full_slot12", 64'(out_data[51:48]), 64'hD);
    tick();

    // Backpressure while full
    in_valid = 1'b1;
    in_data  = 4'hF;
    repeat (10) tick();
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_data", 64'(out_data), frame_seq);
    tick();
    in_valid = 1'b0;
    ack_frame();
    @(negedge clk);
    check("ack_out_valid", 64'(out_valid), 64'd0);
    check("ack_in_ready", 64'(in_ready), 64'd1);
    check("ack_count", 64'(count), 64'd0);
    tick();

    // Gapped input
    for (int i = 0; i < N_VOTES; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      send(10);
    end
    @(negedge clk);
    check("gap_out_data", 64'(out_data), 64'hAAAAAAAAAAAAA);
    check("gap_count", 64'(count), 64'(N_VOTES));
    tick();
    ack_frame();

    // Flush after 7 votes with a vote offered
    for (int i = 0; i < 7; i++) send(int'($urandom_range(1, 15)));
    in_valid = 1'b1;
    in_data  = 4'h9;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_data", 64'(out_data), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    for (int i = 0; i < N_VOTES; i++) send(int'($urandom_range(0, 15)));
    @(negedge clk);
    check("flush_refill_valid", 64'(out_valid), 64'd1);
    tick();
    ack_frame();

    // Ack during FILL is ignored; reset mid-frame
    send(3);
    send(4);
    send(5);
    ack_frame();
    @(negedge clk);
    check("fill_ack_count", 64'(count), 64'd3);
    tick();
    send(6);
    send(8);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    tick();
    send(7);
    @(negedge clk);
    check("midrst_slot0", 64'(out_data[3:0]), 64'h7);
    check("midrst_count1", 64'(count), 64'd1);
    tick();

    // Random soak
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      flush    = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = VOTE_W'($urandom_range(0, 15));
      out_ack  = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst_n    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ack  = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
